leading_bit_locator: RTL and testbench

LEADING_BIT_LOCATOR -- requirements
Module: leading_bit_locator

---
 rtl/lbl_pkg.sv | 19 +
 rtl/group_prio_enc.sv | 25 ++
 rtl/leading_bit_locator.sv | 111 +++++++++++
 tb/tb_leading_bit_locator.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lbl_pkg.sv
// Shared types and sizing helpers for the leading-bit locator pipeline.
package lbl_pkg;

  typedef enum logic [1:0] {
    MODE_MSB_INT   = 2'd0,
    MODE_SQRT_SEED = 2'd1,
    MODE_MSB_ABS   = 2'd2,
    MODE_LSB_ABS   = 2'd3
  } lbl_mode_t;

  localparam bit DIR_MSB = 1'b0;
  localparam bit DIR_LSB = 1'b1;

  // Result width: enough for -WIDTH..WIDTH-1 as a signed value.
  function automatic int loc_w(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/group_prio_enc.sv
// Priority encoder returning the index of the highest (DIR_MSB) or lowest (DIR_LSB) set request.
module group_prio_enc
  import lbl_pkg::*;
#(
  parameter int N   = 8,
  parameter bit DIR = DIR_MSB,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx
);

  // Later loop iterations override earlier ones, so scan toward the winning end.
  always_comb begin
    idx = '0;
    if (DIR == DIR_MSB) begin
      for (int i = 0; i < N; i++)
        if (req[i]) idx = IDX_W'(i);
    end else begin
      for (int i = N - 1; i >= 0; i--)
        if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/leading_bit_locator.sv
// Two-stage leading/trailing set-bit locator on a fixed-point vector with valid/ready handshake.
module leading_bit_locator
  import lbl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16,
  parameter int GROUP = 8,
  parameter int TAG_W = 4,
  localparam int LOC_W = loc_w(WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst_,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_vec,
  input  logic [1:0]              in_mode,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [LOC_W-1:0] out_loc,
  output logic                    out_zero,
  output logic [TAG_W-1:0]        out_tag
);

  localparam int NGRP   = WIDTH / GROUP;
  localparam int GIDX_W = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int BIDX_W = (GROUP > 1) ? $clog2(GROUP) : 1;
  localparam logic [WIDTH-1:0] INT_MASK = {WIDTH{1'b1}} << FRAC;

  // Every mode reduces to (bit position - FRAC); SQRT_SEED then halves k rounding up.
  function automatic logic signed [LOC_W-1:0] mode_loc(input lbl_mode_t m, input int pos);
    int rel;
    rel = pos - FRAC;
    if (m == MODE_SQRT_SEED) rel = (rel + 1) >>> 1;
    return LOC_W'(rel);
  endfunction

  lbl_mode_t              mode_in;
  logic [WIDTH-1:0]       masked;
  logic [NGRP-1:0]        flags;
  logic [GIDX_W-1:0]      g_msb, g_lsb, g_sel;

  logic                   vld_p1;
  logic [WIDTH-1:0]       vec_p1;
  logic [NGRP-1:0]        flags_p1;
  logic [GIDX_W-1:0]      gidx_p1;
  lbl_mode_t              mode_p1;
  logic [TAG_W-1:0]       tag_p1;

  logic [GROUP-1:0]       grp_bits;
  logic [BIDX_W-1:0]      b_msb, b_lsb, b_sel;
  logic                   adv_p2;

  assign adv_p2   = !out_valid || out_ready;
  assign in_ready = !vld_p1 || adv_p2;

  // ---- stage 1: integer masking, group flags, group select ----
  always_comb begin
    mode_in = lbl_mode_t'(in_mode);
    masked  = (mode_in == MODE_MSB_INT || mode_in == MODE_SQRT_SEED) ? (in_vec & INT_MASK) : in_vec;
    for (int g = 0; g < NGRP; g++) flags[g] = |masked[g*GROUP +: GROUP];
  end

  group_prio_enc #(.N(NGRP), .DIR(DIR_MSB)) u_grp_msb (.req(flags), .idx(g_msb));
  group_prio_enc #(.N(NGRP), .DIR(DIR_LSB)) u_grp_lsb (.req(flags), .idx(g_lsb));

  assign g_sel = (mode_in == MODE_LSB_ABS) ? g_lsb : g_msb;

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      vld_p1 <= 1'b0;
    end else if (in_ready) begin
      vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      vec_p1   <= masked;
      flags_p1 <= flags;
      gidx_p1  <= g_sel;
      mode_p1  <= mode_in;
      tag_p1   <= in_tag;
    end
  end

  // ---- stage 2: in-group bit select, mode arithmetic, output register ----
  assign grp_bits = vec_p1[int'(gidx_p1)*GROUP +: GROUP];

  group_prio_enc #(.N(GROUP), .DIR(DIR_MSB)) u_bit_msb (.req(grp_bits), .idx(b_msb));
  group_prio_enc #(.N(GROUP), .DIR(DIR_LSB)) u_bit_lsb (.req(grp_bits), .idx(b_lsb));

  assign b_sel = (mode_p1 == MODE_LSB_ABS) ? b_lsb : b_msb;

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      out_valid <= 1'b0;
      out_loc   <= '0;
      out_zero  <= 1'b0;
      out_tag   <= '0;
    end else if (adv_p2) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        out_zero <= ~|flags_p1;
        out_loc  <= (~|flags_p1) ? '0 : mode_loc(mode_p1, int'(gidx_p1)*GROUP + int'(b_sel));
        out_tag  <= tag_p1;
      end
    end
  end

endmodule

// File: tb/tb_leading_bit_locator.sv
// Directed bench for leading_bit_locator with a bit-scan scoreboard model and literal spot checks.
module tb_leading_bit_locator;

  localparam int W  = 32;
  localparam int F  = 16;
  localparam int G  = 8;
  localparam int T  = 4;
  localparam int LW = 6;

  logic                 clk = 1'b0;
  logic                 rst_;
  logic                 in_valid;
  logic                 in_ready;
  logic [W-1:0]         in_vec;
  logic [1:0]           in_mode;
  logic [T-1:0]         in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [LW-1:0] out_loc;
  logic                 out_zero;
  logic [T-1:0]         out_tag;

  leading_bit_locator #(.WIDTH(W), .FRAC(F), .GROUP(G), .TAG_W(T)) dut (
    .clk(clk), .rst_(rst_),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_loc(out_loc), .out_zero(out_zero), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct { int loc; bit zero; logic [T-1:0] tag; } exp_t;
  exp_t q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: scan every bit and apply the mode rules directly.
  function automatic void model(input logic [W-1:0] v, input logic [1:0] m, output int loc, output bit zero);
    int hi = -1;
    int lo = -1;
    for (int i = 0; i < W; i++)
      if (v[i]) begin
        if (lo < 0) lo = i;
        hi = i;
      end
    loc = 0;
    zero = 1'b0;
    case (m)
      2'd0: if (hi >= F) loc = hi - F; else zero = 1'b1;
      2'd1: if (hi >= F) loc = (hi - F + 1) / 2; else zero = 1'b1;
      2'd2: if (hi >= 0) loc = hi - F; else zero = 1'b1;
      default: if (lo >= 0) loc = lo - F; else zero = 1'b1;
    endcase
  endfunction

  // Offer one beat and return #1 after the edge that transferred it.
  task automatic send(input logic [W-1:0] v, input logic [1:0] m, input logic [T-1:0] t);
    int loc;
    bit z;
    int waited = 0;
    in_valid = 1'b1;
    in_vec   = v;
    in_mode  = m;
    in_tag   = t;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("send_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model(v, m, loc, z);
    q.push_back('{loc, z, t});
    #1;
  endtask

  // Single beat with literal expectations and latency check.
  task automatic run_one(input logic [W-1:0] v, input logic [1:0] m, input logic [T-1:0] t,
                         input int eloc, input bit ez, input string name);
    out_ready = 1'b1;
    send(v, m, t);
    in_valid = 1'b0;
    chk({name, "_early_valid"}, out_valid, 0);
    @(posedge clk); #1;
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_loc"}, out_loc, eloc);
    chk({name, "_zero"}, out_zero, ez);
    @(posedge clk); #1;
  endtask

  // Scoreboard compare and hold-stability check on every cycle.
  bit stalled = 1'b0;
  int p_loc;
  bit p_zero;
  logic [T-1:0] p_tag;
  exp_t e;

  always @(negedge clk) begin
    if (rst_) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_loc", out_loc, 0);
      chk("rst_out_zero", out_zero, 0);
      chk("rst_out_tag", out_tag, 0);
      stalled = 1'b0;
    end else if (out_valid) begin
      if (stalled) begin
        chk("hold_loc", out_loc, p_loc);
        chk("hold_zero", out_zero, p_zero);
        chk("hold_tag", out_tag, p_tag);
      end
      if (out_ready) begin
        stalled = 1'b0;
        if (q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          e = q.pop_front();
          chk("sb_loc", out_loc, e.loc);
          chk("sb_zero", out_zero, e.zero);
          chk("sb_tag", out_tag, e.tag);
        end
      end else begin
        stalled = 1'b1;
        p_loc   = out_loc;
        p_zero  = out_zero;
        p_tag   = out_tag;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] vecs [8] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h0001_0000,
                             32'h0000_FFFF, 32'h1234_5678, 32'h00F0_0F00, 32'h7FFF_0000};
  bit saw_low;
  int guard;

  initial begin
    rst_ = 1'b1;
    in_valid = 1'b0;
    in_vec = '0;
    in_mode = '0;
    in_tag = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    rst_ = 1'b0;
    #1;
    chk("reset_in_ready", in_ready, 1);

    run_one(32'h0005_0000, 2'd0, 4'd1, 2, 1'b0, "msb_int_5");
    run_one(32'h0005_0000, 2'd1, 4'd2, 1, 1'b0, "sqrt_5");
    run_one(32'h0008_0000, 2'd1, 4'd3, 2, 1'b0, "sqrt_8");
    run_one(32'h0001_0000, 2'd1, 4'd4, 0, 1'b0, "sqrt_1");
    run_one(32'h0000_8000, 2'd0, 4'd5, 0, 1'b1, "msb_int_frac_only");
    run_one(32'h0000_8000, 2'd2, 4'd6, -1, 1'b0, "msb_abs_half");
    run_one(32'h8000_0001, 2'd2, 4'd7, 15, 1'b0, "msb_abs_top");
    run_one(32'h8000_0001, 2'd3, 4'd8, -16, 1'b0, "lsb_abs_bottom");
    run_one(32'h0000_0000, 2'd3, 4'd9, 0, 1'b1, "lsb_abs_zero");

    // All modes over a vector table, with out_ready toggling.
    fork
      begin
        for (int m = 0; m < 4; m++)
          for (int i = 0; i < 8; i++)
            send(vecs[i], 2'(m), 4'(m * 8 + i));
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 60; c++) begin
          @(posedge clk); #1;
          out_ready = (c % 3) != 2;
        end
        out_ready = 1'b1;
      end
    join
    guard = 0;
    while (q.size() != 0 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("table_drained", q.size(), 0);

    // Back-to-back stream with a 4-cycle stall in the middle.
    saw_low = 1'b0;
    fork
      begin
        for (int t = 0; t < 6; t++)
          send(vecs[t] | 32'h0100_0000, 2'(t % 4), 4'(t));
        in_valid = 1'b0;
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        repeat (20) begin
          @(negedge clk);
          if (in_valid && !in_ready) saw_low = 1'b1;
        end
      end
    join
    guard = 0;
    while (q.size() != 0 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("stall_in_ready_dropped", saw_low, 1);
    chk("stall_drained", q.size(), 0);

    // Asynchronous reset with two beats in flight.
    out_ready = 1'b1;
    send(32'h0005_0000, 2'd0, 4'd10);
    send(32'h0008_0000, 2'd0, 4'd11);
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1);
    #2;
    rst_ = 1'b1;
    q.delete();
    #1;
    chk("async_rst_valid", out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    rst_ = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_no_output", out_valid, 0);

    run_one(32'h0005_0000, 2'd0, 4'd12, 2, 1'b0, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
